// File: rtl/instr_encoder.sv
// Encoder/issuer for the 9-bit ISA. It turns {op, mode, operand} requests into machine words
// and inserts SETMODE words ahead of mode-dependent ops. Optional macro: ENC_MODE_TRACK_EN.
//
// state     | meaning
// IDLE      | accepting requests whenever the output slot is free
// EMIT_MODE | SETMODE pending, waiting for the slot to free
// EMIT_OP   | SETMODE loaded, held op word goes out next
// HALT      | DONE issued, only Reset leaves
module instr_encoder #(
  parameter logic [7:0] MODE_DEP_MASK = 8'b0001_1111,
  parameter int         COUNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [2:0]         ReqOp,
  input  logic [1:0]         ReqMode,
  input  logic [5:0]         ReqOperand,
  output logic               InstValid,
  input  logic               InstReady,
  output logic [8:0]         Instruction,
  output logic               Halted,
  output logic               Err,
  output logic [COUNT_W-1:0] InstCount
);

  localparam logic [2:0] OP_SETMODE = 3'b110;
  localparam logic [2:0] OP_DONE    = 3'b111;

  typedef enum logic [1:0] {IDLE, EMIT_MODE, EMIT_OP, HALT} state_t;

  state_t             state, state_nxt;
  logic [8:0]         hold_word, hold_word_nxt;
  logic [1:0]         hold_mode, hold_mode_nxt;
  logic [1:0]         cur_mode, cur_mode_nxt;
  logic               mode_known, mode_known_nxt;
  logic               err_nxt;
  logic               load;
  logic [8:0]         load_word;
  logic               slot_free;
  logic               needs_setmode;

  assign slot_free     = !InstValid || InstReady;
  assign needs_setmode = MODE_DEP_MASK[ReqOp] && (!mode_known || (cur_mode != ReqMode));
  assign Halted        = (state == HALT);

  always_comb begin
    state_nxt      = state;
    hold_word_nxt  = hold_word;
    hold_mode_nxt  = hold_mode;
    cur_mode_nxt   = cur_mode;
    mode_known_nxt = mode_known;
    err_nxt        = 1'b0;
    load           = 1'b0;
    load_word      = Instruction;
    ReqReady       = 1'b0;
    case (state)
      IDLE: begin
        ReqReady = slot_free;
        if (ReqValid && slot_free) begin
          if (ReqOp == OP_SETMODE) begin
            err_nxt = 1'b1;
          end else if (ReqOp == OP_DONE) begin
            load      = 1'b1;
            load_word = {OP_DONE, 6'b0};
            state_nxt = HALT;
          end else if (needs_setmode) begin
            hold_word_nxt = {ReqOp, ReqOperand};
            hold_mode_nxt = ReqMode;
            cur_mode_nxt  = ReqMode;
`ifdef ENC_MODE_TRACK_EN
            mode_known_nxt = 1'b1;
`endif
            // Accept implies a free slot, so SETMODE normally loads at once.
            if (slot_free) begin
              load      = 1'b1;
              load_word = {OP_SETMODE, 4'b0, ReqMode};
              state_nxt = EMIT_OP;
            end else begin
              state_nxt = EMIT_MODE;
            end
          end else begin
            load      = 1'b1;
            load_word = {ReqOp, ReqOperand};
          end
        end
      end
      EMIT_MODE: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = {OP_SETMODE, 4'b0, hold_mode};
          state_nxt = EMIT_OP;
        end
      end
      EMIT_OP: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = hold_word;
          state_nxt = IDLE;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      hold_word   <= 9'h000;
      hold_mode   <= 2'b00;
      cur_mode    <= 2'b00;
      mode_known  <= 1'b0;
      Err         <= 1'b0;
      InstValid   <= 1'b0;
      Instruction <= 9'h000;
      InstCount   <= '0;
    end else begin
      state      <= state_nxt;
      hold_word  <= hold_word_nxt;
      hold_mode  <= hold_mode_nxt;
      cur_mode   <= cur_mode_nxt;
      mode_known <= mode_known_nxt;
      Err        <= err_nxt;
      if (load) begin
        InstValid   <= 1'b1;
        Instruction <= load_word;
      end else if (InstReady) begin
        InstValid <= 1'b0;
      end
      if (InstValid && InstReady) begin
        InstCount <= InstCount + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic checked against a
// word-queue reference model of the encoder's stream.
module tb_instr_encoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqOp;
  logic [1:0]  ReqMode;
  logic [5:0]  ReqOperand;
  logic        InstValid;
  logic        InstReady;
  logic [8:0]  Instruction;
  logic        Halted;
  logic        Err;
  logic [15:0] InstCount;

  instr_encoder dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqMode(ReqMode), .ReqOperand(ReqOperand),
    .InstValid(InstValid), .InstReady(InstReady), .Instruction(Instruction),
    .Halted(Halted), .Err(Err), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model: words still owed to the sink, in order
  logic [8:0]  exp_q[$];
  logic [8:0]  got_log[$];
  logic        known_m;
  logic [1:0]  mode_m;
  logic        halted_m;
  logic        err_pend;
  logic [15:0] count_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    got_log.delete();
    known_m  = 1'b0;
    mode_m   = 2'b00;
    halted_m = 1'b0;
    err_pend = 1'b0;
    count_m  = 16'd0;
  endtask

  task automatic model_accept(input logic [2:0] op, input logic [1:0] md, input logic [5:0] od);
    if (op == 3'd6) begin
      err_pend = 1'b1;
    end else if (op == 3'd7) begin
      exp_q.push_back(9'b111_000000);
      halted_m = 1'b1;
    end else if (op <= 3'd4 && (!known_m || mode_m != md)) begin
      exp_q.push_back({3'b110, 4'b0000, md});
      exp_q.push_back({op, od});
      mode_m = md;
`ifdef ENC_MODE_TRACK_EN
      known_m = 1'b1;
`endif
    end else begin
      exp_q.push_back({op, od});
    end
  endtask

  task automatic cycle(input logic v, input logic [2:0] op, input logic [1:0] md,
                       input logic [5:0] od, input logic rdy, output logic acc);
    logic exp_rr;
    @(negedge Clk);
    ReqValid = v; ReqOp = op; ReqMode = md; ReqOperand = od; InstReady = rdy;
    #1;
    exp_rr = !halted_m && (exp_q.size() == 0 || (exp_q.size() == 1 && rdy));
    check("err", {31'b0, Err}, {31'b0, err_pend});
    check("halted", {31'b0, Halted}, {31'b0, halted_m});
    check("count", {16'b0, InstCount}, {16'b0, count_m});
    check("inst_valid", {31'b0, InstValid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("word", {23'b0, Instruction}, {23'b0, exp_q[0]});
    check("req_ready", {31'b0, ReqReady}, {31'b0, exp_rr});
    acc = v && ReqReady;
    err_pend = 1'b0;
    if (InstValid && rdy) begin
      got_log.push_back(Instruction);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      count_m = count_m + 16'd1;
    end
    if (acc) model_accept(op, md, od);
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] md, input logic [5:0] od,
                      input int rdy_pct);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++)
      cycle(1'b1, op, md, od, ($urandom_range(0, 99) < rdy_pct), acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input int rdy_pct);
    logic acc;
    for (int i = 0; i < n; i++)
      cycle(1'b0, 3'd0, 2'd0, 6'd0, ($urandom_range(0, 99) < rdy_pct), acc);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; ReqValid = 1'b0; InstReady = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_clear();
    #1;
    check("rst_valid", {31'b0, InstValid}, 32'd0);
    check("rst_word", {23'b0, Instruction}, 32'd0);
    check("rst_halted", {31'b0, Halted}, 32'd0);
    check("rst_err", {31'b0, Err}, 32'd0);
    check("rst_count", {16'b0, InstCount}, 32'd0);
  endtask

  initial begin
    logic acc;
    logic [2:0] rop;
    Reset = 1'b0; ReqValid = 1'b0; ReqOp = 3'd0; ReqMode = 2'd0;
    ReqOperand = 6'd0; InstReady = 1'b0;
    model_clear();
    do_reset();

    // T1
    send(3'b000, 2'b01, 6'h05, 100);
    idle(3, 100);
    check("t1_len", got_log.size(), 32'd2);
    if (got_log.size() == 2) begin
      check("t1_w0", {23'b0, got_log[0]}, {23'b0, 9'b110_000001});
      check("t1_w1", {23'b0, got_log[1]}, {23'b0, 9'b000_000101});
    end
    check("t1_count", {16'b0, InstCount}, 32'd2);

    // T2
    got_log.delete();
    send(3'b010, 2'b01, 6'h3F, 100);
    idle(3, 100);
`ifdef ENC_MODE_TRACK_EN
    check("t2_len", got_log.size(), 32'd1);
`else
    check("t2_len", got_log.size(), 32'd2);
`endif
    if (got_log.size() != 0)
      check("t2_last", {23'b0, got_log[got_log.size()-1]}, {23'b0, 9'b010_111111});

    // T3: stall during a pair
    send(3'b001, 2'b10, 6'h11, 100);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 3'b101, 2'b00, 6'h01, 1'b0, acc);
      check("t3_hold", {25'b0, Instruction[8:2]}, {25'b0, 7'b1100000});
    end
    idle(4, 100);

    // T4: illegal op
    got_log.delete();
    send(3'b110, 2'b00, 6'h15, 100);
    cycle(1'b0, 3'd0, 2'd0, 6'd0, 1'b1, acc);
    check("t4_no_word", got_log.size(), 32'd0);
    send(3'b101, 2'b00, 6'h07, 100);
    idle(3, 100);

    // T6: reset while a SETMODE is held
    do_reset();
    send(3'b011, 2'b10, 6'h22, 0);
    cycle(1'b0, 3'd0, 2'd0, 6'd0, 1'b0, acc);
    do_reset();
    idle(3, 100);
    got_log.delete();
    send(3'b011, 2'b10, 6'h22, 100);
    idle(3, 100);
    if (got_log.size() != 0)
      check("t6_resend", {23'b0, got_log[0]}, {23'b0, 9'b110_000010});

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 6));
      send(rop, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 70);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 50);
    end
    idle(8, 100);

    // T5: DONE
    got_log.delete();
    send(3'b111, 2'b00, 6'h2A, 100);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 3'b000, 2'b11, 6'h01, 1'b1, acc);
    check("t5_len", got_log.size(), 32'd1);
    if (got_log.size() != 0)
      check("t5_done", {23'b0, got_log[0]}, {23'b0, 9'b111_000000});
    do_reset();
    idle(2, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
